// File: rtl/alu_sequencer.sv
// Four-register accumulator-style sequencer driving an external 4-bit ALU
// through a READ/EXEC/WB pipeline. Define ALU_SEQ_ZFLAG_EN to add the zflag output.
module alu_sequencer #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [1:0]        in_rd,
  input  logic [1:0]        in_rs,
  input  logic              in_imm_sel,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_f,
  input  logic [DATA_W-1:0] alu_y,
  output logic              done,
  output logic [DATA_W-1:0] result,
`ifdef ALU_SEQ_ZFLAG_EN
  output logic              zflag,
`endif
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic [2:0]        r_op;
  logic [1:0]        r_rd;
  logic [1:0]        r_rs;
  logic              r_imm_sel;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] r_regs [NREGS];

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) w_next = S_READ;
      end
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operands are captured in READ, so rd == rs sees the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_rs      <= '0;
      r_imm_sel <= 1'b0;
      r_imm     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_y       <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_op      <= in_op;
        r_rd      <= in_rd;
        r_rs      <= in_rs;
        r_imm_sel <= in_imm_sel;
        r_imm     <= in_imm;
      end
      if (r_state == S_READ) begin
        r_a <= r_regs[r_rd];
        r_b <= r_imm_sel ? r_imm : r_regs[r_rs];
      end
      if (r_state == S_EXEC) begin
        r_y <= alu_y;
      end
      if (r_state == S_WB) begin
        r_regs[r_rd] <= r_y;
      end
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  logic r_zflag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zflag <= 1'b0;
    end else if (r_state == S_WB) begin
      r_zflag <= (r_y == '0);
    end
  end

  assign zflag = r_zflag;
`endif

  // y_q only changes entering WB, so it doubles as the held result.
  assign result   = r_y;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_f    = r_op;
  assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: external ALU model, per-cycle
// comparison against a transaction-level reference, directed and random stimulus.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs;
  logic       in_imm_sel;
  logic [3:0] in_imm;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_f;
  logic [3:0] alu_y;
  logic       done;
  logic [3:0] result;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
`ifdef ALU_SEQ_ZFLAG_EN
  logic       zflag;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu_sequencer #(.DATA_W(4), .NREGS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_imm_sel (in_imm_sel),
    .in_imm     (in_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_y      (alu_y),
    .done       (done),
    .result     (result),
`ifdef ALU_SEQ_ZFLAG_EN
    .zflag      (zflag),
`endif
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a & ~b;
      3'd4:    return b;
      3'd5:    return a - b;
      3'd6:    return (a < b) ? a : b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  // External combinational ALU.
  assign alu_y = alu_fn(alu_f, alu_a, alu_b);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an instruction completes 3 edges after acceptance; its whole
  // effect is computed from the register image at acceptance time.
  int         m_busy;
  logic [3:0] m_regs [4];
  logic [1:0] m_rd;
  logic [3:0] m_a, m_b, m_y, m_res;
  logic [3:0] m_alu_a, m_alu_b;
  logic [2:0] m_alu_f;
  logic       m_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 0;
      for (int i = 0; i < 4; i++) m_regs[i] <= 4'h0;
      m_rd    <= 2'd0;
      m_a     <= 4'h0;
      m_b     <= 4'h0;
      m_y     <= 4'h0;
      m_res   <= 4'h0;
      m_alu_a <= 4'h0;
      m_alu_b <= 4'h0;
      m_alu_f <= 3'd0;
      m_z     <= 1'b0;
    end else if (m_busy == 0) begin
      if (in_valid) begin
        m_busy  <= 3;
        m_rd    <= in_rd;
        m_a     <= m_regs[in_rd];
        m_b     <= in_imm_sel ? in_imm : m_regs[in_rs];
        m_y     <= alu_fn(in_op, m_regs[in_rd], in_imm_sel ? in_imm : m_regs[in_rs]);
        m_alu_f <= in_op;
      end
    end else begin
      m_busy <= m_busy - 1;
      if (m_busy == 3) begin
        m_alu_a <= m_a;
        m_alu_b <= m_b;
      end
      if (m_busy == 2) m_res <= m_y;
      if (m_busy == 1) begin
        m_regs[m_rd] <= m_res;
        m_z          <= (m_res == 4'h0);
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_busy == 0);
    check("done", done, m_busy == 1);
    check("result", result, m_res);
    check("alu_a", alu_a, m_alu_a);
    check("alu_b", alu_b, m_alu_b);
    check("alu_f", alu_f, m_alu_f);
    check("dbg_data", dbg_data, m_regs[dbg_addr]);
`ifdef ALU_SEQ_ZFLAG_EN
    check("zflag", zflag, m_z);
`endif
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic sel, input logic [3:0] imm, input logic [3:0] exp_res);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_imm_sel = sel; in_imm = imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!done && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", k + 1, 3);
      check("issue_result", result, exp_res);
      dbg_addr = rd;
      @(posedge clk); #1;
      check("done_single", done, 0);
      check("issue_dbg", dbg_data, exp_res);
    end
  endtask

  initial begin
    int dpos [$];
    int ndone;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_rd = 2'd0; in_rs = 2'd0;
    in_imm_sel = 1'b0; in_imm = 4'h0; dbg_addr = 2'd0;
    #12 rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      check("rst_reg", dbg_data, 0);
    end

    issue(3'd4, 2'd1, 2'd0, 1'b1, 4'h7, 4'h7);
    issue(3'd4, 2'd1, 2'd0, 1'b1, 4'h9, 4'h9);
    issue(3'd4, 2'd2, 2'd0, 1'b1, 4'h8, 4'h8);
    issue(3'd2, 2'd1, 2'd2, 1'b0, 4'h0, 4'h1);
    issue(3'd4, 2'd1, 2'd0, 1'b1, 4'h1, 4'h1);
    issue(3'd4, 2'd2, 2'd0, 1'b1, 4'h2, 4'h2);
    issue(3'd5, 2'd1, 2'd2, 1'b0, 4'h0, 4'hF);
    issue(3'd2, 2'd1, 2'd1, 1'b0, 4'h0, 4'hE);
    issue(3'd4, 2'd0, 2'd0, 1'b1, 4'h5, 4'h5);
    issue(3'd4, 2'd3, 2'd0, 1'b1, 4'h5, 4'h5);
    issue(3'd6, 2'd0, 2'd3, 1'b0, 4'h0, 4'h5);
    issue(3'd7, 2'd0, 2'd3, 1'b0, 4'h0, 4'h5);
    issue(3'd0, 2'd3, 2'd0, 1'b1, 4'hC, 4'h4);
    issue(3'd1, 2'd3, 2'd0, 1'b1, 4'h2, 4'h6);
    issue(3'd3, 2'd3, 2'd0, 1'b1, 4'h2, 4'h4);
    issue(3'd4, 2'd1, 2'd0, 1'b1, 4'h6, 4'h6);
    issue(3'd5, 2'd1, 2'd0, 1'b1, 4'h6, 4'h0);
`ifdef ALU_SEQ_ZFLAG_EN
    check("zflag_set", zflag, 1);
`endif
    issue(3'd2, 2'd1, 2'd0, 1'b1, 4'h1, 4'h1);
`ifdef ALU_SEQ_ZFLAG_EN
    check("zflag_clr", zflag, 0);
`endif

    // Back-pressure: fixed increment of r2 offered for 12 edges.
    issue(3'd4, 2'd2, 2'd0, 1'b1, 4'h0, 4'h0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd2; in_rd = 2'd2; in_rs = 2'd0; in_imm_sel = 1'b1; in_imm = 4'h1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dpos.push_back(i);
    end
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) dpos.push_back(99);
    end
    check("bp_done_count", dpos.size(), 3);
    if (dpos.size() == 3) begin
      check("bp_first_done", dpos[0], 2);
      check("bp_spacing1", dpos[1] - dpos[0], 4);
      check("bp_spacing2", dpos[2] - dpos[1], 4);
    end
    dbg_addr = 2'd2; #1;
    check("bp_r2", dbg_data, 3);

    // Reset while the ADD sits in EXEC.
    issue(3'd4, 2'd1, 2'd0, 1'b1, 4'h3, 4'h3);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd2; in_rd = 2'd1; in_imm_sel = 1'b1; in_imm = 4'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_done", done, 0);
    #5 rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst_mid_no_done", ndone, 0);
    check("rst_mid_ready2", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      check("rst_mid_reg", dbg_data, 0);
    end

    // Random traffic; in_valid toggles freely, including while busy.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(0, 2) != 0);
      in_op      = 3'($urandom);
      in_rd      = 2'($urandom);
      in_rs      = 2'($urandom);
      in_imm_sel = 1'($urandom);
      in_imm     = 4'($urandom);
      dbg_addr   = 2'($urandom);
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 4, operand/result width; only 4 is supported because the ALU is 4-bit.
REQ-002 SHALL have parameter NREGS, default 4, register file depth; address width is 2.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, instruction offered.
REQ-006 SHALL have port in_ready, output, 1, sequencer can accept an instruction.
REQ-007 SHALL have port in_op, input, 3, ALU function code: 000 AND, 001 OR, 010 ADD, 011 A&~B, 100 MOV, 101 SUB, 110 MIN, 111 MAX.
REQ-008 SHALL have port in_rd, input, 2, destination register and A-operand source.
REQ-009 SHALL have port in_rs, input, 2, B-operand source register.
REQ-010 SHALL have port in_imm_sel, input, 1, B operand taken from in_imm instead of regs[in_rs].
REQ-011 SHALL have port in_imm, input, 4, immediate B operand.
REQ-012 SHALL have ports alu_a/alu_b, output, 4 each, and alu_f, output, 3, driving the external ALU.
REQ-013 SHALL have port alu_y, input, 4, combinational ALU result.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port result, output, 4, value written in the completing instruction.
REQ-016 SHALL have ports dbg_addr, input, 2, and dbg_data, output, 4, a combinational register-file read port.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> EXEC -> WB -> IDLE with no other states.
REQ-018 SHALL assert in_ready only in IDLE; accept the instruction on a clk edge with in_valid && in_ready, latching op, rd, rs, imm_sel, imm, and entering READ.
REQ-019 SHALL, in READ, register a_q = regs[rd] and b_q = imm_sel ? imm : regs[rs], then enter EXEC.
REQ-020 SHALL, in EXEC, drive alu_a = a_q, alu_b = b_q, alu_f = latched op, register alu_y into y_q, then enter WB.
REQ-021 SHALL, in WB, assert done = 1 and result = y_q for exactly one cycle, write y_q into regs[rd] at the end of that cycle, then enter IDLE.
REQ-022 SHALL drive alu_a/alu_b/alu_f from registers at all times; they change only on READ/accept edges.
REQ-023 SHALL give latency of exactly 3 cycles from the accept edge to the edge that ends done, with a maximum throughput of one instruction per 4 cycles.
REQ-024 SHALL hold result at its last value when done = 0.
REQ-025 SHALL return the pre-write value on dbg_data when dbg_addr equals rd during WB, and the new value from the following cycle.
REQ-026 SHALL handle rd == rs correctly, since both operands are read in READ before any write.
REQ-027 SHALL ignore in_valid while not in IDLE, without latching any fields.
REQ-028 SHALL wrap arithmetic modulo 16, with no carry or borrow output.

Reset
REQ-029 SHALL, on rst_n low, immediately clear state to IDLE, regs[0..3] to 0, a_q/b_q/y_q/op to 0, done to 0, result to 0, and set in_ready to 1 after release.
REQ-030 SHALL, on reset mid-instruction, abort it with no register write and no done pulse.

Configuration
REQ-031 SHALL, with macro ALU_SEQ_ZFLAG_EN defined, add output zflag (1 bit, reset 0), updated in WB to (y_q == 0) and held otherwise.
REQ-032 SHALL, without ALU_SEQ_ZFLAG_EN, have no zflag port and no flag logic.

Verification
REQ-033 SHALL cover load: MOV rd=1, imm_sel=1, imm=4'h7 -> done 3 cycles after accept, result=7, dbg_data(1)=7.
REQ-034 SHALL cover wrap: r1=9, r2=8, ADD rd=1, rs=2 -> result=4'h1; SUB r1=1, r2=2 -> 4'hF.
REQ-035 SHALL cover back-pressure: in_valid held high for 12 cycles with a fixed instruction -> exactly 3 accepts and 3 done pulses spaced 4 cycles apart.
REQ-036 SHALL cover MIN/MAX with equal operands: r0=5, r3=5, op 110 rd=0, rs=3 -> 5; op 111 -> 5.
REQ-037 SHALL cover reset in EXEC: r1=3, ADD imm=2 rd=1, rst_n pulsed low in EXEC -> no done, all regs 0, in_ready=1.
REQ-038 SHALL cover the flag with ALU_SEQ_ZFLAG_EN: SUB r1=6, imm=6 -> result=0, zflag=1; next ADD imm=1 -> zflag=0.
